// File: rtl/ex_me_pkg.sv
// Shared types for the EX->ME pipeline register: lane payload layout,
// payload width and the occupancy state encoding.
package ex_me_pkg;

    // One issue lane's worth of EX results handed to ME.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] bradd;
        logic [31:0] wtdat;
        logic        zero;
        logic [2:0]  branchop;
        logic [3:0]  memop;
        logic [4:0]  rd;
        logic        regwrite;
        logic [1:0]  rfwt_sel;
        logic        order;
    } ex_me_lane_t;

    localparam int unsigned EX_ME_DATA_W = $bits(ex_me_lane_t);

    // Number of held bundles is encoded directly in the state value.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } ex_me_state_e;

    function automatic logic [1:0] occ_of_state(ex_me_state_e st);
        logic [1:0] occ;
        unique case (st)
            StEmpty: occ = 2'd0;
            StOne:   occ = 2'd1;
            StTwo:   occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/ex_me_bundle_reg.sv
// Load-enabled bundle register (per-lane valid + payload) with synchronous
// clear. Clear wins over load.
module ex_me_bundle_reg
    import ex_me_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = EX_ME_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic [LANES-1:0]        d_valid_i,
    input  logic [LANES*DATA_W-1:0] d_data_i,
    output logic [LANES-1:0]        q_valid_o,
    output logic [LANES*DATA_W-1:0] q_data_o
);

    logic [LANES-1:0]        valid_d, valid_q;
    logic [LANES*DATA_W-1:0] data_d, data_q;

    // Next-state: clear, load or hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = '0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = d_valid_i;
            data_d  = d_data_i;
        end
    end

    // Storage flops, cleared asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign q_valid_o = valid_q;
    assign q_data_o  = data_q;

endmodule

// File: rtl/ex_me_pipe_reg.sv
// EX->ME pipeline register: main entry M drives ME, skid entry S absorbs the
// bundle accepted in the cycle ME stalls, so in_ready can be a flop.
module ex_me_pipe_reg
    import ex_me_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = EX_ME_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_ready,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt
);

    ex_me_state_e            state_d, state_q;
    logic                    in_ready_d, in_ready_q;
    logic [CNT_W-1:0]        stall_d, stall_q;

    logic                    present, accept, emit, stalled;
    logic [LANES*DATA_W-1:0] in_data_masked;

    logic                    m_load, m_clr, s_load, s_clr;
    logic [LANES-1:0]        m_src_valid, m_valid, s_valid;
    logic [LANES*DATA_W-1:0] m_src_data, m_data, s_data;

    // Lanes without valid are stored as zero so ME never sees stale payload.
    always_comb begin
        in_data_masked = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid[i]) begin
                in_data_masked[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign present = |in_valid;
    assign accept  = present & in_ready_q;
    assign emit    = (|m_valid) & out_ready;
    assign stalled = (|m_valid) & ~out_ready;

    // M refills from S when draining TWO, otherwise from the input bundle.
    assign m_src_valid = (state_q == StTwo) ? s_valid : in_valid;
    assign m_src_data  = (state_q == StTwo) ? s_data  : in_data_masked;

    // Occupancy FSM and storage control; flush outranks accept and emit.
    always_comb begin
        state_d = state_q;
        m_load  = 1'b0;
        m_clr   = 1'b0;
        s_load  = 1'b0;
        s_clr   = 1'b0;
        if (flush) begin
            state_d = StEmpty;
            m_clr   = 1'b1;
            s_clr   = 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        m_load  = 1'b1;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        m_load = 1'b1;
                    end else if (accept) begin
                        s_load  = 1'b1;
                        state_d = StTwo;
                    end else if (emit) begin
                        m_clr   = 1'b1;
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (emit) begin
                        m_load  = 1'b1;
                        s_clr   = 1'b1;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    m_clr   = 1'b1;
                    s_clr   = 1'b1;
                end
            endcase
        end
    end

    // in_ready follows the next state, so out_ready never reaches it combinationally.
    always_comb begin
        in_ready_d = (state_d != StTwo);
    end

    // Saturating count of cycles ME holds off a valid bundle; flush leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (stalled && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Control state, ready flop and stall counter.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    ex_me_bundle_reg #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i     (CLK),
        .rst_ni    (RST_n),
        .clr_i     (m_clr),
        .load_i    (m_load),
        .d_valid_i (m_src_valid),
        .d_data_i  (m_src_data),
        .q_valid_o (m_valid),
        .q_data_o  (m_data)
    );

    ex_me_bundle_reg #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i     (CLK),
        .rst_ni    (RST_n),
        .clr_i     (s_clr),
        .load_i    (s_load),
        .d_valid_i (in_valid),
        .d_data_i  (in_data_masked),
        .q_valid_o (s_valid),
        .q_data_o  (s_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = occ_of_state(state_q);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_ex_me_pipe_reg.sv
// Directed bench for ex_me_pipe_reg: LANES=2, CNT_W=4 so saturation is reachable.
module tb_ex_me_pipe_reg;
    import ex_me_pkg::*;

    localparam int unsigned LANES = 2;
    localparam int unsigned DW    = EX_ME_DATA_W;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BW    = LANES * DW;

    logic             CLK = 1'b0;
    logic             RST_n;
    logic             flush;
    logic [LANES-1:0] in_valid;
    logic [BW-1:0]    in_data;
    logic             in_ready;
    logic [LANES-1:0] out_valid;
    logic [BW-1:0]    out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    ex_me_pipe_reg #(
        .LANES  (LANES),
        .DATA_W (DW),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    function automatic logic [DW-1:0] mk_lane(input logic [31:0] pc, input logic ord);
        ex_me_lane_t l;
        l          = '0;
        l.pc       = pc;
        l.alu      = ~pc;
        l.bradd    = pc + 32'h40;
        l.wtdat    = {pc[15:0], pc[31:16]};
        l.zero     = pc[3];
        l.branchop = pc[6:4];
        l.memop    = 4'h3;
        l.rd       = pc[6:2];
        l.regwrite = 1'b1;
        l.rfwt_sel = 2'b10;
        l.order    = ord;
        return l;
    endfunction

    // Lane 0 holds the older instruction (order 0), lane 1 the next one.
    function automatic logic [BW-1:0] mk_bundle(input logic [31:0] pc);
        return {mk_lane(pc + 32'd4, 1'b1), mk_lane(pc, 1'b0)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [LANES-1:0] v, input logic [31:0] pc);
        in_valid = v;
        in_data  = mk_bundle(pc);
    endtask

    logic [BW-1:0] exp_data;

    initial begin
        RST_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #1 RST_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, '0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1);
        check("rst_occupancy", occupancy, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        tick();
        tick();
        RST_n = 1'b1;
        tick();

        // Streaming: each bundle shows up one cycle after it is presented.
        for (int k = 0; k < 8; k++) begin
            drive(2'b11, 32'h100 + 32'(8 * k));
            tick();
            check($sformatf("stream%0d_valid", k), out_valid, 2'b11);
            check($sformatf("stream%0d_data", k), out_data, mk_bundle(32'h100 + 32'(8 * k)));
            check($sformatf("stream%0d_ready", k), in_ready, 1);
            check($sformatf("stream%0d_occ", k), occupancy, 1);
        end
        in_valid = '0;
        tick();
        check("stream_drain_valid", out_valid, '0);
        check("stream_drain_occ", occupancy, 0);
        check("stream_stall", stall_cnt, 0);

        // Backpressure: A then B fill M and S, C waits for in_ready.
        out_ready = 1'b0;
        drive(2'b11, 32'h200);
        tick();
        check("bp_a_data", out_data, mk_bundle(32'h200));
        check("bp_a_occ", occupancy, 1);
        drive(2'b11, 32'h208);
        tick();
        check("bp_two_occ", occupancy, 2);
        check("bp_two_ready", in_ready, 0);
        check("bp_two_hold_a", out_data, mk_bundle(32'h200));
        drive(2'b11, 32'h210);
        tick();
        check("bp_c_blocked_occ", occupancy, 2);
        check("bp_c_blocked_data", out_data, mk_bundle(32'h200));
        check("bp_stall2", stall_cnt, 2);
        out_ready = 1'b1;
        tick();
        check("bp_b_data", out_data, mk_bundle(32'h208));
        check("bp_b_occ", occupancy, 1);
        check("bp_b_ready", in_ready, 1);
        tick();
        check("bp_c_data", out_data, mk_bundle(32'h210));
        check("bp_c_valid", out_valid, 2'b11);
        in_valid = '0;
        tick();
        check("bp_drain_occ", occupancy, 0);
        check("bp_stall_kept", stall_cnt, 2);

        // Partial bundle: lane 1 invalid comes out zeroed.
        drive(2'b01, 32'h300);
        tick();
        exp_data            = mk_bundle(32'h300);
        exp_data[BW-1:DW]   = '0;
        check("part_valid", out_valid, 2'b01);
        check("part_data", out_data, exp_data);
        in_valid = '0;
        tick();
        check("part_drain_valid", out_valid, '0);

        // Flush with two held bundles and a new one presented.
        out_ready = 1'b0;
        drive(2'b11, 32'h400);
        tick();
        drive(2'b11, 32'h408);
        tick();
        check("fl2_occ_before", occupancy, 2);
        drive(2'b11, 32'h410);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = '0;
        check("fl2_valid", out_valid, '0);
        check("fl2_ready", in_ready, 1);
        check("fl2_occ", occupancy, 0);
        check("fl2_stall", stall_cnt, 4);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl2_nothing_later", out_valid, '0);
        check("fl2_occ_later", occupancy, 0);

        // Flush outranks an acceptable bundle in ONE.
        out_ready = 1'b0;
        drive(2'b11, 32'h500);
        tick();
        check("fl1_occ_before", occupancy, 1);
        drive(2'b11, 32'h508);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = '0;
        check("fl1_valid", out_valid, '0);
        check("fl1_occ", occupancy, 0);
        check("fl1_stall", stall_cnt, 5);

        // Asynchronous reset with two bundles held.
        drive(2'b11, 32'h600);
        tick();
        drive(2'b11, 32'h608);
        tick();
        in_valid = '0;
        check("rm_occ_before", occupancy, 2);
        check("rm_stall_before", stall_cnt, 6);
        RST_n = 1'b0;
        #1;
        check("rm_valid", out_valid, '0);
        check("rm_data", out_data, '0);
        check("rm_ready", in_ready, 1);
        check("rm_occ", occupancy, 0);
        check("rm_stall", stall_cnt, 0);
        tick();
        RST_n = 1'b1;
        tick();

        // Stall counter saturation; output must hold steady meanwhile.
        out_ready = 1'b0;
        drive(2'b11, 32'h700);
        tick();
        in_valid = '0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_cnt", stall_cnt, 15);
        check("sat_hold_data", out_data, mk_bundle(32'h700));
        tick();
        tick();
        check("sat_stays", stall_cnt, 15);
        out_ready = 1'b1;
        tick();
        check("sat_drain_occ", occupancy, 0);
        check("sat_after_drain", stall_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
